// File: rtl/rr_mux_pkg.sv
// rr_mux_pkg: shared mode encodings, default geometry and helpers for the rr_mux slice.
package rr_mux_pkg;
    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int k = 0; k < 31; k++) if ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

    localparam int N_DEF  = 4;
    localparam int W_DEF  = 8;
    localparam int SW_DEF = clog2(N_DEF);

    typedef enum logic {EMPTY, FULL} ost_t;
endpackage

// File: rtl/rr_mux_if.sv
// rr_mux_if: producer-side and consumer-side handshake bundle of rr_mux.
// RR_MUX_PARITY_EN adds the registered even-parity bit y_par.
interface rr_mux_if #(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int SW = 2
);
    logic           mode;
    logic [SW-1:0]  s;
    logic [N*W-1:0] i;
    logic [N-1:0]   i_valid;
    logic [N-1:0]   i_ready;
    logic [W-1:0]   y;
    logic [SW-1:0]  y_ch;
    logic           y_valid;
    logic           y_ready;
`ifdef RR_MUX_PARITY_EN
    logic           y_par;
    modport master (output mode, s, i, i_valid, y_ready,
                    input  i_ready, y, y_ch, y_valid, y_par);
    modport slave  (input  mode, s, i, i_valid, y_ready,
                    output i_ready, y, y_ch, y_valid, y_par);
`else
    modport master (output mode, s, i, i_valid, y_ready,
                    input  i_ready, y, y_ch, y_valid);
    modport slave  (input  mode, s, i, i_valid, y_ready,
                    output i_ready, y, y_ch, y_valid);
`endif
endinterface

// File: rtl/rr_arb.sv
// rr_arb: combinational rotate-priority picker; first requester after ptr wins.
module rr_arb #(
    parameter int N  = 4,
    parameter int SW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic          grant_vld,
    output logic [SW-1:0] grant_idx
);
    // Scan farthest-first so the nearest requester after ptr overwrites the rest.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = N; k >= 1; k--) begin
            if (req[(int'(ptr) + k) % N]) begin
                grant_vld = 1'b1;
                grant_idx = SW'((int'(ptr) + k) % N);
            end
        end
    end
endmodule

// File: rtl/rr_mux.sv
// rr_mux: N-channel registered mux, fixed-select or round-robin, valid/ready both sides.
// RR_MUX_PARITY_EN adds y_par, even parity registered alongside y.
module rr_mux
    import rr_mux_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int W  = W_DEF,
    parameter int SW = clog2(N)
) (
    input logic    clk,
    input logic    rst_n,
    rr_mux_if.slave bus
);
    ost_t          st;
    logic [SW-1:0] ptr;
    logic [W-1:0]  y_q;
    logic [SW-1:0] ch_q;
    logic          arb_vld;
    logic [SW-1:0] arb_idx;
    logic          fix_vld;
    logic          grant;
    logic [SW-1:0] g;
    logic          load;
    logic [N-1:0]  one_hot;

    rr_arb #(.N(N), .SW(SW)) u_arb (
        .req       (bus.i_valid),
        .ptr       (ptr),
        .grant_vld (arb_vld),
        .grant_idx (arb_idx)
    );

    // Selects beyond N-1 (non-power-of-two N) simply never grant.
    assign fix_vld = (int'(bus.s) < N) ? bus.i_valid[bus.s] : 1'b0;
    assign grant   = (bus.mode == MODE_RR) ? arb_vld : fix_vld;
    assign g       = (bus.mode == MODE_RR) ? arb_idx : bus.s;
    assign load    = (st == EMPTY) || bus.y_ready;
    assign one_hot = {{(N-1){1'b0}}, 1'b1} << g;

    assign bus.i_ready = (load && grant) ? one_hot : '0;
    assign bus.y       = y_q;
    assign bus.y_ch    = ch_q;
    assign bus.y_valid = (st == FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st   <= EMPTY;
            y_q  <= '0;
            ch_q <= '0;
            ptr  <= SW'(N - 1);
        end else if (load) begin
            st <= grant ? FULL : EMPTY;
            if (grant) begin
                y_q  <= bus.i[int'(g)*W +: W];
                ch_q <= g;
            end
            if (grant && bus.mode == MODE_RR) ptr <= g;
        end
    end

`ifdef RR_MUX_PARITY_EN
    logic par_q;
    assign bus.y_par = par_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) par_q <= 1'b0;
        else if (load && grant) par_q <= ^bus.i[int'(g)*W +: W];
    end
`endif
endmodule

// File: tb/tb_rr_mux.sv
// tb_rr_mux: directed-vector bench for rr_mux with N=4, W=8.
module tb_rr_mux;
    logic clk;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    rr_mux_if #(.N(4), .W(8), .SW(2)) bus ();

    rr_mux #(.N(4), .W(8), .SW(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.mode    = 1'b1;
        bus.s       = 2'd0;
        bus.i       = {8'h13, 8'h12, 8'h11, 8'h10};
        bus.i_valid = 4'hF;
        bus.y_ready = 1'b1;
        #12;
        chk("rst_y", 32'(bus.y), 32'h0);
        chk("rst_y_valid", 32'(bus.y_valid), 32'h0);
        chk("rst_y_ch", 32'(bus.y_ch), 32'h0);
`ifdef RR_MUX_PARITY_EN
        chk("rst_y_par", 32'(bus.y_par), 32'h0);
`endif
        rst_n = 1'b1;
        #1;
        chk("first_rr_ready", 32'(bus.i_ready), 32'h1);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("rr_y_ch", 32'(bus.y_ch), 32'(k % 4));
            chk("rr_y", 32'(bus.y), 32'h10 + 32'(k % 4));
            chk("rr_y_valid", 32'(bus.y_valid), 32'h1);
        end
        step();
        chk("bp_setup_y", 32'(bus.y), 32'h11);
        bus.y_ready = 1'b0;
        #1;
        chk("bp_ready0", 32'(bus.i_ready), 32'h0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("bp_y", 32'(bus.y), 32'h11);
            chk("bp_y_ch", 32'(bus.y_ch), 32'h1);
            chk("bp_y_valid", 32'(bus.y_valid), 32'h1);
            chk("bp_i_ready", 32'(bus.i_ready), 32'h0);
        end
        bus.y_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(bus.i_ready), 32'h4);
        step();
        chk("bp_release_y", 32'(bus.y), 32'h12);
        chk("bp_release_ch", 32'(bus.y_ch), 32'h2);
        bus.i_valid = 4'h0;
        bus.mode    = 1'b0;
        #1;
        chk("idle_ready", 32'(bus.i_ready), 32'h0);
        step();
        chk("drain_valid", 32'(bus.y_valid), 32'h0);
        chk("drain_y_hold", 32'(bus.y), 32'h12);
        bus.s          = 2'd2;
        bus.i[23:16]   = 8'hA5;
        bus.i_valid    = 4'b0100;
        #1;
        chk("fix_ready", 32'(bus.i_ready), 32'h4);
        step();
        chk("fix_y", 32'(bus.y), 32'hA5);
        chk("fix_y_ch", 32'(bus.y_ch), 32'h2);
        chk("fix_y_valid", 32'(bus.y_valid), 32'h1);
        bus.s = 2'd1;
        #1;
        chk("fix_miss_ready", 32'(bus.i_ready), 32'h0);
        step();
        chk("fix_miss_valid", 32'(bus.y_valid), 32'h0);
        bus.mode    = 1'b1;
        bus.i_valid = 4'b1000;
        step();
        chk("sp_ch3", 32'(bus.y_ch), 32'h3);
        bus.i_valid = 4'b1010;
        #1;
        chk("sp_ready", 32'(bus.i_ready), 32'h2);
        step();
        chk("sp_g1", 32'(bus.y_ch), 32'h1);
        step();
        chk("sp_g3", 32'(bus.y_ch), 32'h3);
        step();
        chk("sp_wrap_g1", 32'(bus.y_ch), 32'h1);
        chk("sp_wrap_y", 32'(bus.y), 32'h11);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus.y_valid), 32'h0);
        chk("mid_rst_y", 32'(bus.y), 32'h0);
        #3;
        rst_n = 1'b1;
`ifdef RR_MUX_PARITY_EN
        bus.mode    = 1'b0;
        bus.s       = 2'd0;
        bus.i[7:0]  = 8'h07;
        bus.i_valid = 4'b0001;
        step();
        chk("par_07", 32'(bus.y_par), 32'h1);
        bus.i[7:0] = 8'h03;
        step();
        chk("par_03", 32'(bus.y_par), 32'h0);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
